// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC hit path.
// Hit word layout is {cal_err, bcid, toa, tot, cal}.
package tdc_pkg;

    localparam int TOA_W      = 10;
    localparam int TOT_W      = 9;
    localparam int CAL_W      = 10;
    localparam int BCID_W     = 12;
    localparam int BC_MAX_DEF = 3563;

    typedef struct packed {
        logic              cal_err;
        logic [BCID_W-1:0] bcid;
        logic [TOA_W-1:0]  toa;
        logic [TOT_W-1:0]  tot;
        logic [CAL_W-1:0]  cal;
    } tdc_hit_t;

    localparam int HIT_W = $bits(tdc_hit_t);

endpackage

// File: rtl/tdc_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit to tell full from empty.
module tdc_sync_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      wptr_n;
    logic [AW:0]      rptr_n;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_n  = wptr + (AW+1)'(do_push);
        rptr_n  = rptr + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            empty <= (wptr_n == rptr_n);
            full  <= (wptr_n[AW] != rptr_n[AW]) &&
                     (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Masked so a never-written slot cannot leak out after reset
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/tdc_hit_buffer.sv
// Per-pixel hit buffer: TOA window filter, BCID tagging, show-ahead FIFO.
// Define TDC_CAL_CHECK_EN to flag out-of-range Cal codes in cal_err.
module tdc_hit_buffer
    import tdc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int BC_MAX = BC_MAX_DEF,
    parameter int CAL_LO = 100,
    parameter int CAL_HI = 400
) (
    input  logic              clk40,
    input  logic              reset,
    input  logic              bc_rst,
    input  logic [BCID_W-1:0] bc_preset,
    input  logic              hit_valid,
    input  logic [TOA_W-1:0]  toa,
    input  logic [TOT_W-1:0]  tot,
    input  logic [CAL_W-1:0]  cal,
    input  logic [TOA_W-1:0]  win_lo,
    input  logic [TOA_W-1:0]  win_hi,
    output logic [HIT_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [7:0]        ovf_cnt
);

`ifdef TDC_CAL_CHECK_EN
    localparam bit CAL_CHK = 1'b1;
`else
    localparam bit CAL_CHK = 1'b0;
`endif

    localparam logic [BCID_W-1:0] BC_TOP = BCID_W'(BC_MAX);

    logic [BCID_W-1:0] bcid;
    logic              in_win;
    logic              cal_err;
    logic              s1_valid;
    tdc_hit_t          s1_word;
    tdc_hit_t          s1_next;
    logic              pop;
    logic              push;
    logic              drop;

    always_ff @(posedge clk40) begin
        if (reset) begin
            bcid <= '0;
        end else if (bc_rst) begin
            bcid <= (bc_preset > BC_TOP) ? BC_TOP : bc_preset;
        end else if (bcid == BC_TOP) begin
            bcid <= '0;
        end else begin
            bcid <= bcid + 12'd1;
        end
    end

    // CAL_CHK folds to 0 without the macro, leaving no comparator
    always_comb begin
        in_win  = hit_valid && (toa >= win_lo) && (toa <= win_hi);
        cal_err = CAL_CHK &&
                  ((cal < CAL_W'(CAL_LO)) || (cal > CAL_W'(CAL_HI)));
        s1_next = {cal_err, bcid, toa, tot, cal};
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= in_win;
            s1_word  <= s1_next;
        end
    end

    always_comb begin
        pop  = dout_valid && dout_ready;
        push = s1_valid && (!fifo_full || pop);
        drop = s1_valid && fifo_full && !pop;
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    tdc_sync_fifo #(
        .WIDTH (HIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk40),
        .reset (reset),
        .push  (push),
        .wdata (s1_word),
        .pop   (pop),
        .rdata (dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign dout_valid = !fifo_empty;

endmodule

// File: doc/tdc_hit_buffer.md
# tdc_hit_buffer

Per-pixel hit buffer directly downstream of the TDC controller and encoder. Each clk40 cycle, it samples the encoded TOA/TOT/Cal word that is presented after the controller's encoded-data write strobe. It applies a programmable TOA acceptance window, tags each accepted hit with the current bunch-crossing ID, and stores it in a small FIFO. The FIFO is drained by the pixel readout through a valid/ready handshake.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..16.
- BC_MAX, 3563: last BCID value before wrap to 0.
- CAL_LO, 100: lowest legal Cal code (used only with the macro enabled).
- CAL_HI, 400: highest legal Cal code (used only with the macro enabled).
- clk40  in  1  40 MHz bunch-crossing clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- bc_rst  in  1  one-cycle pulse; loads BCID counter with bc_preset.
- bc_preset  in  12  BCID load value.
- hit_valid  in  1  encoded data word valid this cycle.
- toa  in  10  encoded TOA code.
- tot  in  9  encoded TOT code.
- cal  in  10  encoded Cal code.
- win_lo, win_hi  in  10 each  inclusive TOA acceptance window.
- dout  out  42  {cal_err, bcid[11:0], toa, tot, cal}.
- dout_valid  out  1  dout holds an unread entry.
- dout_ready  in  1  consumer accepts dout this cycle.
- fifo_empty, fifo_full  out  1 each  FIFO status.
- ovf_cnt  out  8  saturating count of dropped hits.

## Operation
- BCID counter: increments every cycle and wraps BC_MAX→0. bc_rst loads bc_preset, and this takes priority over the increment. A bc_preset value greater than BC_MAX is clamped to BC_MAX.
- Stage 1 (filter/tag): a word is captured when hit_valid=1 and win_lo ≤ toa ≤ win_hi. The comparison is unsigned, 10-bit.
  - The word is tagged with the BCID value of the sampling cycle, before that cycle's increment.
  - If win_lo > win_hi, every hit is rejected.
  - Rejected hits are discarded silently and are not counted.
- Stage 2 (FIFO): a registered stage-1 word is written if the FIFO is not full, or if it is full and a read happens in the same cycle. Otherwise the word is dropped (newest is lost) and ovf_cnt increments, saturating at 255.
- Read side: show-ahead. dout always presents the oldest entry, and dout_valid = !fifo_empty. A pop occurs when dout_valid & dout_ready. dout_ready while empty has no effect.
- Simultaneous push and pop: both occur and the occupancy is unchanged. On an empty FIFO, a push with dout_ready=1 is not bypassed; the word appears the following cycle.
- Read and write pointers are log2(DEPTH)+1 bits. Full and empty are derived from the MSB/LSB pointer comparison, and the pointers wrap naturally.
- Reset (synchronous, any time): pointers=0, BCID=0, ovf_cnt=0 and stage-1 valid=0. An in-flight stage-1 word is lost. After reset, dout_valid=0, fifo_empty=1, fifo_full=0 and dout=0.

## Timing
- The hit sampled at edge N is written at edge N+1. dout_valid rises after edge N+1, giving 2-cycle latency from the hit_valid cycle to the visible output.
- The status flags (fifo_empty, fifo_full) and ovf_cnt are registered and update in the same cycle as the pointers.
- A sustained 1 hit/cycle with dout_ready held at 1 gives 1 hit/cycle throughput with no drops.
- bc_rst in cycle N: a hit in cycle N carries the pre-load BCID, and a hit in cycle N+1 carries bc_preset.

## Configuration
- Macro: TDC_CAL_CHECK_EN.
- Defined: cal_err = (cal < CAL_LO) || (cal > CAL_HI), computed in stage 1 and stored with the entry. Errored hits are still buffered.
- Undefined: cal_err is tied to 0, there is no comparator logic, and the dout width stays at 42.

## Structure
- Shared package tdc_pkg holds:
  - the constants TOA_W=10, TOT_W=9, CAL_W=10, BCID_W=12;
  - a packed struct tdc_hit_t for {cal_err, bcid, toa, tot, cal};
  - the default BC_MAX.
- One sub-module: tdc_sync_fifo (a parameterised show-ahead FIFO with a full/empty/push/pop interface). The filter, BCID counter and overflow logic stay in the top level.

## Test plan
- Reset, then 5 hits with toa=0,50,200,900,1023 and win_lo=50, win_hi=900 -> exactly 3 entries, in order toa=50,200,900; ovf_cnt=0.
- dout_ready=0 and 10 accepted hits with DEPTH=8 -> fifo_full after the 8th; ovf_cnt=2; draining yields the first 8 in order, then fifo_empty=1.
- FIFO full plus a hit and dout_ready=1 in the same cycle -> no drop; occupancy stays at 8; ovf_cnt unchanged.
- bc_preset=3560 with a bc_rst pulse, then a hit every cycle for 6 cycles -> BCIDs 3560,3561,3562,3563,0,1.
- With TDC_CAL_CHECK_EN defined: hits with cal=99,100,400,401 -> cal_err=1,0,0,1. Without the macro, all four give cal_err=0.
- Reset asserted with 4 entries buffered and a hit in stage 1 -> the next cycle shows dout_valid=0, ovf_cnt=0, and no stale entry ever appears.
